// File: rtl/dbg_bus_arbiter.sv
// Arbiter sharing the data-memory port and register-file debug port between
// the pipeline and the debugger; drains in-flight pipeline accesses first.
module dbg_bus_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dbg_valid,
   input  logic        dbg_mem_rd,
   input  logic        dbg_mem_wr,
   input  logic        dbg_rf_rd,
   input  logic        dbg_rf_wr,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_d_in,
   input  logic        mcu_paused,
   output logic        dbg_busy,
   output logic [31:0] dbg_d_rd,
   output logic        dbg_error,
   input  logic        cpu_mem_req,
   input  logic        cpu_mem_we,
   input  logic [31:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_wdata,
   output logic [31:0] cpu_mem_rdata,
   output logic        cpu_mem_ack,
   output logic        cpu_stall,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [4:0]  rf_addr,
   output logic        rf_we,
   output logic [31:0] rf_wdata,
   input  logic [31:0] rf_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, DBG_MEM, DBG_RF} state_t;

   state_t        state_q, state_d;
   logic          cpu_pend_q, cpu_pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   d_rd_q, d_rd_d;
   logic          err_q, err_d;
   logic          op_wr_q, op_wr_d;
   logic          op_rf_q, op_rf_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;

   logic [3:0]    ops;
   logic          oneHot;
   logic          isRf;
   logic          fwdCpu;

   assign ops    = {dbg_mem_rd, dbg_mem_wr, dbg_rf_rd, dbg_rf_wr};
   assign oneHot = (ops != 4'd0) && ((ops & 4'(ops - 4'd1)) == 4'd0);
   assign isRf   = dbg_rf_rd | dbg_rf_wr;

   always_comb begin
      state_d     = state_q;
      cpu_pend_d  = cpu_pend_q;
      cnt_d       = '0;
      d_rd_d      = d_rd_q;
      err_d       = 1'b0;
      op_wr_d     = op_wr_q;
      op_rf_d     = op_rf_q;
      addr_d      = addr_q;
      data_d      = data_q;
      fwdCpu      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      cpu_mem_ack = 1'b0;
      cpu_stall   = 1'b0;
      rf_addr     = 5'h0;
      rf_we       = 1'b0;
      rf_wdata    = 32'h0;

      case (state_q)
         IDLE: begin
            fwdCpu = 1'b1;
            if (dbg_valid) begin
               if (!oneHot) begin
                  err_d = 1'b1;
               end else if (isRf && !mcu_paused) begin
                  err_d = 1'b1;
               end else if (!isRf && (dbg_addr[1:0] != 2'b00)) begin
                  err_d = 1'b1;
               end else begin
                  op_wr_d = dbg_mem_wr | dbg_rf_wr;
                  op_rf_d = isRf;
                  addr_d  = dbg_addr;
                  data_d  = dbg_d_in;
                  if (cpu_pend_q) begin
                     state_d = DRAIN;
                  end else begin
                     // Debugger wins a same-cycle tie: the pipeline request is held back.
                     state_d   = isRf ? DBG_RF : DBG_MEM;
                     fwdCpu    = 1'b0;
                     cpu_stall = 1'b1;
                  end
               end
            end
         end
         DRAIN: begin
            fwdCpu = 1'b1;
            if (mem_ack) begin
               state_d = op_rf_q ? DBG_RF : DBG_MEM;
            end
         end
         DBG_MEM: begin
            cpu_stall = 1'b1;
            mem_en    = 1'b1;
            mem_we    = op_wr_q;
            mem_addr  = addr_q;
            mem_wdata = data_q;
            if (mem_ack) begin
               if (!op_wr_q) begin
                  d_rd_d = mem_rdata;
               end
               state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DBG_RF: begin
            cpu_stall = 1'b1;
            rf_addr   = addr_q[4:0];
            rf_we     = op_wr_q;
            rf_wdata  = op_wr_q ? data_q : 32'h0;
            if (!op_wr_q) begin
               d_rd_d = rf_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (fwdCpu) begin
         mem_en      = cpu_mem_req;
         mem_we      = cpu_mem_we;
         mem_addr    = cpu_mem_addr;
         mem_wdata   = cpu_mem_wdata;
         cpu_mem_ack = mem_ack;
         if (mem_ack) begin
            cpu_pend_d = 1'b0;
         end else if (cpu_mem_req) begin
            cpu_pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cpu_pend_q <= 1'b0;
         cnt_q      <= '0;
         d_rd_q     <= 32'h0;
         err_q      <= 1'b0;
         op_wr_q    <= 1'b0;
         op_rf_q    <= 1'b0;
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
      end else begin
         state_q    <= state_d;
         cpu_pend_q <= cpu_pend_d;
         cnt_q      <= cnt_d;
         d_rd_q     <= d_rd_d;
         err_q      <= err_d;
         op_wr_q    <= op_wr_d;
         op_rf_q    <= op_rf_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign dbg_busy      = (state_q != IDLE);
   assign dbg_error     = err_q;
   assign dbg_d_rd      = d_rd_q;
   assign cpu_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Scoreboard bench for dbg_bus_arbiter: expected responses are queued at
// stimulus time and popped by a monitor when the DUT completes an access.
module tb_dbg_bus_arbiter;

   localparam int TO = 8;
   localparam logic [3:0] MRD = 4'b1000;
   localparam logic [3:0] MWR = 4'b0100;
   localparam logic [3:0] RRD = 4'b0010;
   localparam logic [3:0] RWR = 4'b0001;

   logic        clk = 1'b0;
   logic        reset;
   logic        dbg_valid, dbg_mem_rd, dbg_mem_wr, dbg_rf_rd, dbg_rf_wr;
   logic [31:0] dbg_addr, dbg_d_in;
   logic        mcu_paused;
   logic        dbg_busy, dbg_error;
   logic [31:0] dbg_d_rd;
   logic        cpu_mem_req, cpu_mem_we;
   logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
   logic        cpu_mem_ack, cpu_stall;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic [4:0]  rf_addr;
   logic        rf_we;
   logic [31:0] rf_wdata, rf_rdata;

   typedef struct {
      bit          isErr;
      logic [31:0] data;
   } dbgExp_t;

   dbgExp_t     dbgExpQ[$];
   logic [31:0] cpuExpQ[$];
   logic [31:0] memModel [logic [31:0]];
   logic [31:0] rfModel [32];
   int          checks = 0;
   int          errors = 0;
   int          cpuAckCount = 0;
   int          ackLat = 0;
   bit          ackEn = 1'b1;
   bit          rfWeSeen = 1'b0;
   bit          prevBusy = 1'b0;
   int          waitCnt = 0;

   dbg_bus_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .dbg_valid(dbg_valid), .dbg_mem_rd(dbg_mem_rd), .dbg_mem_wr(dbg_mem_wr),
      .dbg_rf_rd(dbg_rf_rd), .dbg_rf_wr(dbg_rf_wr),
      .dbg_addr(dbg_addr), .dbg_d_in(dbg_d_in), .mcu_paused(mcu_paused),
      .dbg_busy(dbg_busy), .dbg_d_rd(dbg_d_rd), .dbg_error(dbg_error),
      .cpu_mem_req(cpu_mem_req), .cpu_mem_we(cpu_mem_we),
      .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
      .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_ack(cpu_mem_ack), .cpu_stall(cpu_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return memModel.exists(a) ? memModel[a] : 32'h0;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: acks after ackLat extra cycles of a held mem_en.
   always @(posedge clk) begin
      #2;
      if (reset || mem_ack) begin
         mem_ack = 1'b0;
         waitCnt = 0;
      end else if (mem_en && ackEn) begin
         if (waitCnt == ackLat) begin
            mem_ack   = 1'b1;
            mem_rdata = memRead(mem_addr);
            if (mem_we) memModel[mem_addr] = mem_wdata;
         end else begin
            waitCnt++;
         end
      end else if (!mem_en) begin
         waitCnt = 0;
      end
   end

   always_comb rf_rdata = rfModel[rf_addr];

   always @(negedge clk) begin
      if (rf_we) begin
         rfModel[rf_addr] = rf_wdata;
         rfWeSeen = 1'b1;
      end
   end

   // Monitor: pops an expectation on every pipeline ack and every debugger completion.
   always @(negedge clk) begin
      if (!reset) begin
         if (cpu_mem_ack) begin
            cpuAckCount++;
            if (cpuExpQ.size() == 0) begin
               checkVal("unexpected cpu ack", 32'h1, 32'h0);
            end else begin
               checkVal("cpu rdata", cpu_mem_rdata, cpuExpQ.pop_front());
            end
         end
         if (dbg_error || (prevBusy && !dbg_busy)) begin
            if (dbgExpQ.size() == 0) begin
               checkVal("unexpected dbg completion", 32'h1, 32'h0);
            end else begin
               dbgExp_t e;
               e = dbgExpQ.pop_front();
               checkVal("dbg error flag", 32'(dbg_error), 32'(e.isErr));
               checkVal("dbg_d_rd", dbg_d_rd, e.data);
            end
         end
         prevBusy = dbg_busy;
      end
   end

   task automatic cpuRead(input logic [31:0] addr, input logic [31:0] expData);
      int n = 0;
      bit done = 1'b0;
      cpuExpQ.push_back(expData);
      @(posedge clk); #1;
      cpu_mem_req = 1'b1; cpu_mem_we = 1'b0; cpu_mem_addr = addr;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
         if (cpu_mem_ack) done = 1'b1;
      end
      if (!done) checkVal("cpu ack timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      cpu_mem_req = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] ops, input logic [31:0] addr,
                                input logic [31:0] data, input bit tieCheck);
      @(posedge clk); #1;
      {dbg_mem_rd, dbg_mem_wr, dbg_rf_rd, dbg_rf_wr} = ops;
      dbg_valid = 1'b1; dbg_addr = addr; dbg_d_in = data;
      @(negedge clk);
      if (tieCheck) begin
         checkVal("tie mem_en", 32'(mem_en), 32'h0);
         checkVal("tie cpu_stall", 32'(cpu_stall), 32'h1);
      end
      @(posedge clk); #1;
      dbg_valid = 1'b0;
      {dbg_mem_rd, dbg_mem_wr, dbg_rf_rd, dbg_rf_wr} = 4'b0;
   endtask

   task automatic waitIdle(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dbg_busy && n < 2000);
      if (dbg_busy) checkVal("busy timeout", 32'h1, 32'h0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkVal(name, act, exp);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int bad;
      int ackBefore;
      reset = 1'b1;
      dbg_valid = 1'b0; dbg_mem_rd = 1'b0; dbg_mem_wr = 1'b0; dbg_rf_rd = 1'b0; dbg_rf_wr = 1'b0;
      dbg_addr = 32'h0; dbg_d_in = 32'h0; mcu_paused = 1'b0;
      cpu_mem_req = 1'b0; cpu_mem_we = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0;
      for (int i = 0; i < 32; i++) rfModel[i] = 32'h0;
      memModel[32'h100] = 32'hDEADBEEF;
      memModel[32'h104] = 32'h01040104;
      memModel[32'h300] = 32'h30303030;
      memModel[32'h304] = 32'h04040404;
      memModel[32'h308] = 32'h08080808;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", 32'(dbg_busy), 32'h0);
      checkOutput("reset error", 32'(dbg_error), 32'h0);
      checkOutput("reset d_rd", dbg_d_rd, 32'h0);
      checkOutput("reset stall", 32'(cpu_stall), 32'h0);
      checkOutput("reset mem_en", 32'(mem_en), 32'h0);
      checkOutput("reset rf_we", 32'(rf_we), 32'h0);

      // Pass-through pipeline read
      ackLat = 2;
      bad = 0;
      fork
         cpuRead(32'h100, 32'hDEADBEEF);
         repeat (5) begin
            @(negedge clk);
            if (cpu_stall || dbg_busy) bad++;
         end
      join
      checkOutput("passthru stall/busy cycles", bad, 0);

      // Debugger write then read
      ackLat = 1;
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h0});
      applyStimulus(MWR, 32'h200, 32'h12345678, 1'b0);
      waitIdle(n);
      checkOutput("mem wr latency", n, 3);
      checkOutput("mem wr stored", memRead(32'h200), 32'h12345678);
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h12345678});
      applyStimulus(MRD, 32'h200, 32'h0, 1'b0);
      waitIdle(n);
      checkOutput("mem rd latency", n, 3);

      // Drain of an in-flight pipeline read
      ackLat = 3;
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h30303030});
      fork
         begin
            cpuRead(32'h308, 32'h08080808);
            cpuRead(32'h304, 32'h04040404);
         end
         begin
            @(posedge clk);
            applyStimulus(MRD, 32'h300, 32'h0, 1'b0);
            waitIdle(n);
            checkOutput("retry forwarded en", 32'(mem_en), 32'h1);
            checkOutput("retry forwarded addr", mem_addr, 32'h304);
         end
         begin
            bad = 0;
            while (!cpu_mem_ack && bad < 100) begin
               @(negedge clk);
               bad++;
            end
            checkOutput("drain ack stall", 32'(cpu_stall), 32'h0);
            @(negedge clk);
            checkOutput("post-drain mem_en", 32'(mem_en), 32'h1);
            checkOutput("post-drain addr", mem_addr, 32'h300);
            checkOutput("post-drain stall", 32'(cpu_stall), 32'h1);
         end
      join
      repeat (2) @(negedge clk);

      // Tie between pipeline request and debugger command
      ackLat = 1;
      ackBefore = cpuAckCount;
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h01040104});
      fork
         cpuRead(32'h100, 32'hDEADBEEF);
         begin
            applyStimulus(MRD, 32'h104, 32'h0, 1'b1);
            waitIdle(n);
            checkOutput("tie debugger first", cpuAckCount, ackBefore);
            checkOutput("tie pipeline addr", mem_addr, 32'h100);
         end
      join
      repeat (2) @(negedge clk);

      // Register file port
      mcu_paused = 1'b1;
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h01040104});
      applyStimulus(RWR, 32'h5, 32'hA5A5A5A5, 1'b0);
      waitIdle(n);
      checkOutput("rf wr latency", n, 2);
      checkOutput("rf wr stored", rfModel[5], 32'hA5A5A5A5);
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'hA5A5A5A5});
      applyStimulus(RRD, 32'h5, 32'h0, 1'b0);
      waitIdle(n);
      checkOutput("rf rd latency", n, 2);
      mcu_paused = 1'b0;
      rfWeSeen = 1'b0;
      dbgExpQ.push_back('{isErr: 1'b1, data: 32'hA5A5A5A5});
      applyStimulus(RWR, 32'h5, 32'h11111111, 1'b0);
      waitIdle(n);
      @(negedge clk);
      checkOutput("unpaused no rf_we", 32'(rfWeSeen), 32'h0);
      checkOutput("unpaused rf kept", rfModel[5], 32'hA5A5A5A5);

      // Rejected commands
      dbgExpQ.push_back('{isErr: 1'b1, data: 32'hA5A5A5A5});
      applyStimulus(MRD | MWR, 32'h200, 32'h0, 1'b0);
      waitIdle(n);
      @(negedge clk);
      dbgExpQ.push_back('{isErr: 1'b1, data: 32'hA5A5A5A5});
      applyStimulus(MRD, 32'h201, 32'h0, 1'b0);
      waitIdle(n);
      @(negedge clk);

      // Timeout with no memory ack
      ackEn = 1'b0;
      dbgExpQ.push_back('{isErr: 1'b1, data: 32'hA5A5A5A5});
      applyStimulus(MRD, 32'h200, 32'h0, 1'b0);
      waitIdle(n);
      checkOutput("timeout cycle", n, TO + 1);
      checkOutput("timeout mem_en", 32'(mem_en), 32'h0);
      @(negedge clk);

      // Reset during a debugger memory access
      dbgExpQ.push_back('{isErr: 1'b0, data: 32'h0});
      applyStimulus(MRD, 32'h200, 32'h0, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset-abort busy", 32'(dbg_busy), 32'h0);
      checkOutput("reset-abort mem_en", 32'(mem_en), 32'h0);
      checkOutput("reset-abort error", 32'(dbg_error), 32'h0);
      ackEn = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("dbg queue drained", dbgExpQ.size(), 0);
      checkOutput("cpu queue drained", cpuExpQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
